// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit, one product or quotient bit per cycle.
// Define ALU_MULDIV_DIV_EN to build the restoring divider; otherwise divide ops complete as illegal.
module alu_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    localparam int unsigned PW = 2 * XLEN;
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_prod;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_result;
    logic [CW-1:0]   r_cnt;
    logic            r_neg;
    logic            r_sel_hi;
    logic            r_out_valid;
    logic            r_in_ready;
    logic            r_illegal;

    logic            w_accept;
    logic            w_last;
    logic            w_a_sgn;
    logic            w_b_sgn;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN:0]   w_mul_sum;
    logic [PW-1:0]   w_mul_next;
    logic [PW-1:0]   w_mul_signed;
    logic [XLEN-1:0] w_mul_res;

    assign w_accept = in_valid && r_in_ready && !flush;
    assign w_last   = (r_cnt == CW'(XLEN - 1));

    // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 only for MUL/MULH/DIV/REM
    assign w_a_sgn = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
    assign w_b_sgn = funct3[2] ? !funct3[0] : !funct3[1];
    assign w_a_neg = w_a_sgn && op_a[XLEN-1];
    assign w_b_neg = w_b_sgn && op_b[XLEN-1];
    assign w_a_mag = w_a_neg ? (~op_a + XLEN'(1)) : op_a;
    assign w_b_mag = w_b_neg ? (~op_b + XLEN'(1)) : op_b;

    // shift-add: multiplier sits in the low half and is consumed LSB first
    assign w_mul_sum    = {1'b0, r_prod[PW-1:XLEN]} + (r_prod[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_mul_next   = {w_mul_sum, r_prod[XLEN-1:1]};
    assign w_mul_signed = r_neg ? (~w_mul_next + PW'(1)) : w_mul_next;
    assign w_mul_res    = r_sel_hi ? w_mul_signed[PW-1:XLEN] : w_mul_signed[XLEN-1:0];

`ifdef ALU_MULDIV_DIV_EN
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ge;
    logic [PW-1:0]   w_div_next;
    logic [XLEN-1:0] w_div_raw;
    logic [XLEN-1:0] w_div_res;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    // restoring step: partial remainder in the high half, dividend/quotient in the low half
    assign w_div_shift = {r_prod[PW-1:XLEN], r_prod[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ge    = !w_div_diff[XLEN];
    assign w_div_next  = {(w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                          r_prod[XLEN-2:0], w_div_ge};
    assign w_div_raw   = r_sel_hi ? w_div_next[PW-1:XLEN] : w_div_next[XLEN-1:0];
    assign w_div_res   = r_neg ? (~w_div_raw + XLEN'(1)) : w_div_raw;

    assign w_div_zero    = (op_b == '0);
    assign w_div_ovf     = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
    assign w_special     = w_div_zero || w_div_ovf;
    assign w_special_res = w_div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (!funct3[2]) begin
                            w_next = MUL;
`ifdef ALU_MULDIV_DIV_EN
                        end else if (w_special) begin
                            w_next = DONE;
                        end else begin
                            w_next = DIV;
                        end
`else
                        end else begin
                            w_next = DONE;
                        end
`endif
                    end
                end
                MUL:     if (w_last) w_next = DONE;
`ifdef ALU_MULDIV_DIV_EN
                DIV:     if (w_last) w_next = DONE;
`endif
                DONE:    if (out_ready) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // operand capture, iteration and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod      <= '0;
            r_opb       <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_sel_hi    <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == IDLE);
            r_out_valid <= (w_next == DONE);
            if (flush) begin
                r_cnt     <= '0;
                r_result  <= '0;
                r_illegal <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_cnt     <= '0;
                            r_illegal <= 1'b0;
                            r_sel_hi  <= funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
                            r_neg     <= (funct3[2] && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
                            if (!funct3[2]) begin
                                r_prod <= {{XLEN{1'b0}}, w_b_mag};
                                r_opb  <= w_a_mag;
                            end else begin
`ifdef ALU_MULDIV_DIV_EN
                                r_prod <= {{XLEN{1'b0}}, w_a_mag};
                                r_opb  <= w_b_mag;
                                if (w_special) r_result <= w_special_res;
`else
                                r_result  <= '0;
                                r_illegal <= 1'b1;
`endif
                            end
                        end
                    end
                    MUL: begin
                        r_prod <= w_mul_next;
                        r_cnt  <= r_cnt + CW'(1);
                        if (w_last) r_result <= w_mul_res;
                    end
`ifdef ALU_MULDIV_DIV_EN
                    DIV: begin
                        r_prod <= w_div_next;
                        r_cnt  <= r_cnt + CW'(1);
                        if (w_last) r_result <= w_div_res;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (XLEN=32) against an arithmetic reference model.
module tb_alu_muldiv;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ill;
        int          lat;
    } vec_t;

    alu_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // reference: exact RV32M semantics from 64-bit arithmetic; latency in cycles from accept edge
    function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        logic [63:0] sa;
        logic [63:0] sb;
        logic [63:0] p;
`ifdef ALU_MULDIV_DIV_EN
        longint da;
        longint db;
`endif
        ill = 1'b0;
        lat = 33;
        r   = '0;
        if (!f[2]) begin
            sa = (f == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
            sb = f[1] ? {32'b0, b} : {{32{b[31]}}, b};
            p  = sa * sb;
            r  = (f == 3'b000) ? p[31:0] : p[63:32];
        end else begin
`ifdef ALU_MULDIV_DIV_EN
            da = f[0] ? longint'({32'b0, a}) : longint'({{32{a[31]}}, a});
            db = f[0] ? longint'({32'b0, b}) : longint'({{32{b[31]}}, b});
            if (b == 32'd0) begin
                r   = f[1] ? a : 32'hFFFF_FFFF;
                lat = 1;
            end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r   = f[1] ? 32'd0 : a;
                lat = 1;
            end else begin
                r = f[1] ? 32'(da % db) : 32'(da / db);
            end
`else
            ill = 1'b1;
            lat = 1;
`endif
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // issue one op, wait for its result (bounded), then hand it off after 'hold' stall cycles
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] res, output logic ill, output int lat);
        int n;
        lat = -1;
        res = 'x;
        ill = 'x;
        n   = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) return;
        in_valid = 1'b1;
        funct3   = f;
        op_a     = a;
        op_b     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid !== 1'b1) return;
        lat = n;
        res = result;
        ill = illegal;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h ill=%b, required 0 0 0 0",
                     in_ready, out_valid, result, illegal);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        vec_t        v[$];
        logic [31:0] res;
        logic        ill;
        int          lat;
        v.push_back('{"mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33});
        v.push_back('{"mul_max",     3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33});
        v.push_back('{"mulh_minmin", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33});
        v.push_back('{"mulhsu_neg",  3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33});
        v.push_back('{"mul_3x4",     3'b000, 32'd3,         32'd4,         32'd12,        1'b0, 33});
`ifdef ALU_MULDIV_DIV_EN
        v.push_back('{"div_neg7_2",  3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33});
        v.push_back('{"rem_neg7_2",  3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33});
        v.push_back('{"divu_100_7",  3'b101, 32'd100,       32'd7,         32'd14,        1'b0, 33});
        v.push_back('{"remu_100_7",  3'b111, 32'd100,       32'd7,         32'd2,         1'b0, 33});
        v.push_back('{"div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1});
        v.push_back('{"rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1});
        v.push_back('{"divu_5_0",    3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1});
        v.push_back('{"rem_5_0",     3'b110, 32'd5,         32'd0,         32'd5,         1'b0, 1});
`else
        v.push_back('{"divu_9_3",    3'b101, 32'd9,         32'd3,         32'd0,         1'b1, 1});
        v.push_back('{"rem_7_2",     3'b110, 32'd7,         32'd2,         32'd0,         1'b1, 1});
`endif
        foreach (v[i]) begin
            do_op(v[i].f, v[i].a, v[i].b, 0, res, ill, lat);
            n_cmp++;
            if (res !== v[i].r) begin
                n_err++;
                $display("FAIL %s result: got %h, required %h", v[i].name, res, v[i].r);
            end
            n_cmp++;
            if (ill !== v[i].ill) begin
                n_err++;
                $display("FAIL %s illegal: got %b, required %b", v[i].name, ill, v[i].ill);
            end
            n_cmp++;
            if (lat !== v[i].lat) begin
                n_err++;
                $display("FAIL %s latency: got %0d, required %0d", v[i].name, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] er;
        logic        ill;
        logic        ei;
        int          lat;
        int          el;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom);
            a = pick();
            b = pick();
            model(f, a, b, er, ei, el);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_op(f, a, b, $urandom_range(0, 3), res, ill, lat);
            n_cmp++;
            if (res !== er || ill !== ei || lat !== el) begin
                n_err++;
                $display("FAIL random f=%b a=%h b=%h: got res=%h ill=%b lat=%0d, required res=%h ill=%b lat=%0d",
                         f, a, b, res, ill, lat, er, ei, el);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        in_valid = 1'b1; funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            funct3 = 3'b000; op_a = $urandom; op_b = $urandom;
            @(posedge clk); #1;
            n++;
        end
        // in_valid stays high with junk: nothing may be accepted while the result is held
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE || in_ready !== 1'b0 || illegal !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got vld=%b res=%h rdy=%b ill=%b, required 1 fffffffe 0 0",
                         c, out_valid, result, in_ready, illegal);
            end
            op_a = $urandom;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release: got vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] er;
        logic        ei;
        int          el;
        int          n;
        in_valid = 1'b1; funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, er, ei, el);
        // present the next op in the handshake cycle; it must wait for in_ready
        out_ready = 1'b1; in_valid = 1'b1; funct3 = 3'b011; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        n_cmp++;
        if (result !== 32'd42) begin
            n_err++;
            $display("FAIL b2b_first: got %h, required %h", result, 32'd42);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_no_same_cycle: got rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (result !== er || n !== el) begin
            n_err++;
            $display("FAIL b2b_second: got res=%h lat=%0d, required res=%h lat=%0d", result, n, er, el);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic seen;
        in_valid = 1'b1; funct3 = 3'b001; op_a = $urandom; op_b = $urandom;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_mul: got rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL flush_mul_no_result: got out_valid seen=%b, required 0", seen);
        end
        in_valid = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        seen = (in_ready !== 1'b1);
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL flush_blocks_accept: got accepted=%b, required 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        ill;
        int          lat;
        do_op(3'b000, 32'd3, 32'd4, 0, res, ill, lat);
        n_cmp++;
        if (res !== 32'd12) begin
            n_err++;
            $display("FAIL pre_reset_mul: got %h, required %h", res, 32'd12);
        end
        in_valid = 1'b1;
`ifdef ALU_MULDIV_DIV_EN
        funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
`else
        funct3 = 3'b011; op_a = 32'd1000; op_b = 32'd3;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got rdy=%b vld=%b res=%h ill=%b, required 0 0 0 0",
                     in_ready, out_valid, result, illegal);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_release: got rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
        do_op(3'b000, 32'd5, 32'd7, 0, res, ill, lat);
        n_cmp++;
        if (res !== 32'd35 || lat !== 33) begin
            n_err++;
            $display("FAIL post_reset_mul: got res=%h lat=%0d, required res=%h lat=33", res, lat, 32'd35);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
